uart_receiver: RTL
==================

# uart_receiver

Serial receive stage directly downstream of the UART transmitter: samples the `RX` line at 16× the bit rate and recovers 5–9 data bits, optional parity and 1 or 2 stop bits. It uses the same `Baud_Rate_Holding_Register` divisor scheme and a control-field layout matching the transmitter. It presents the received word in `Receiver_Buffer_Register` with ready, error and overrun flags for the bus side, which clears them with a one-cycle `read_ack`.

## Interface
- No parameters.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `Baud_Rate_Holding_Register`  in  32  clk cycles per oversample tick; 0 is treated as 1.
- `Receiver_Control`  in  16  field layout:
  - [0] enable.
  - [4:1] data bits 5–9; any other value means 8.
  - [5] parity enable.
  - [6] parity type: 0 even, 1 odd.
  - [8:7] stop bits: 2'b10 = two, anything else = one.
- `RX`  in  1  serial line, idle high, asynchronous to `clk`.
- `read_ack`  in  1  one-cycle pulse; consumes the buffer.
- `Receiver_Buffer_Register`  out  16  received data right-aligned; unused bits 0.
- `Receiver_Status`  out  8  status bits:
  - [0] data_ready.
  - [1] parity_error.
  - [2] framing_error.
  - [3] overrun.
  - [4] busy (state ≠ IDLE).
  - [7:5] always 0.

## Operation
- `RX` passes through a 2-flop synchronizer (reset value 1) before any use. `rxs` is the synchronizer output.
- Tick generator:
  - Counter runs 0..divisor−1 and emits a 1-cycle tick at divisor−1.
  - It is cleared on start-edge detect and whenever the state is IDLE.
- A 4-bit oversample counter advances on each tick. The sample point is oversample count 7 (mid-bit).
- FSM states: IDLE → START → DATA → PARITY → STOP1 → STOP2 → IDLE.
  - IDLE: when enable=1 and a falling edge on `rxs` is seen, go to START with the counters cleared.
  - START: at the mid-sample, `rxs`=1 is a false start → return to IDLE with no flags changed. Otherwise → DATA.
  - DATA: sample every 16 ticks after the start mid-point. Bits are LSB first into a shift register. After N bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compute the XOR of the data bits and the parity bit. The result must be 0 for even parity and 1 for odd; otherwise latch a pending parity error. → STOP1.
  - STOP1: if `rxs`=0, latch a pending framing error. With two stop bits → STOP2; otherwise complete the frame and → IDLE.
  - STOP2: same sample check as STOP1, then complete the frame → IDLE.
- Frame completion:
  - If data_ready=0: load the buffer, set data_ready and copy the pending parity/framing flags into [1]/[2].
  - If data_ready=1 (no simultaneous `read_ack`): discard the new frame, set overrun, and leave the buffer and flags unchanged.
- `read_ack` clears data_ready, parity_error, framing_error and overrun. With data_ready=0, `read_ack` still clears the flags.
- Simultaneous completion and `read_ack`: completion wins. The new data is loaded, data_ready stays 1, the error flags come from the new frame, and overrun is cleared.
- enable=0 mid-frame: abort to IDLE on the next clk edge. Nothing is written and the flags are kept.
- Control and divisor values are sampled continuously. Software changes them only while busy=0.

## Timing
- Reset (next edge after `rst`=1, from any state):
  - state IDLE and all counters 0.
  - synchronizer flops 1.
  - `Receiver_Buffer_Register` = 0x0000.
  - `Receiver_Status` = 0x00.
- Start latency: the `RX` falling edge reaches the edge detector after 2 clk cycles (synchronizer).
- busy rises on the clk edge after the edge is detected.
- Bit sample k (k=0 is start) occurs 8+16k ticks after the start detect.
- Completion:
  - data_ready and the error flags update on the clk edge following the final stop-bit mid-sample tick.
  - busy falls on that same edge.
- Minimum frame gap is 0: a start edge detected one clk cycle after returning to IDLE is accepted.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: PARITY state and parity checking are present as described above.
  - Undefined: `Receiver_Control`[6:5] is ignored, the PARITY state is absent, and `Receiver_Status`[1] is constant 0. A line parity bit would be treated as the stop bit.

## Test plan
- Divisor 1, control 0x0091 (enable, 8 data, 1 stop), frame 0xA5 8N1 → buffer 0x00A5, status 0x01 on the edge after the stop mid-sample; `read_ack` → status 0x00.
- Macro defined, control 0x00B1 (8 data, even parity), send 0x3C with parity bit 1 → buffer 0x003C, status 0x03.
- Control 0x0091, send 0x55 with stop bit 0 → status 0x05.
- Divisor 3, two back-to-back frames 0x11 then 0x22 with no `read_ack` → buffer 0x0011, status 0x09.
- Low glitch of 4 clk cycles on `RX` (divisor 1) → busy pulses, then returns to 0; status stays 0x00.
- Assert `rst` for one cycle halfway through data bit 3 → next edge: buffer 0x0000, status 0x00.
- Assert `rst` for one cycle halfway through data bit 3, then send 0x7E → received correctly as 0x007E.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Bus-side bundle for uart_receiver: line input, control/divisor, and the
// received-word buffer with its status and read acknowledge.
interface uart_receiver_if;
  logic [31:0] Baud_Rate_Holding_Register;
  logic [15:0] Receiver_Control;
  logic        RX;
  logic        read_ack;
  logic [15:0] Receiver_Buffer_Register;
  logic [7:0]  Receiver_Status;

  modport master (
    output Baud_Rate_Holding_Register,
    output Receiver_Control,
    output RX,
    output read_ack,
    input  Receiver_Buffer_Register,
    input  Receiver_Status
  );

  modport slave (
    input  Baud_Rate_Holding_Register,
    input  Receiver_Control,
    input  RX,
    input  read_ack,
    output Receiver_Buffer_Register,
    output Receiver_Status
  );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver (5-9 data bits, 1/2 stop, parity under UART_RX_PARITY_EN); flags update on the edge after
// the last stop mid-sample. No backpressure: a frame finishing while data_ready is set is dropped and flagged as overrun.
module uart_receiver (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP1, S_STOP2} state_t;
`endif

  state_t      state, state_nxt;
  logic        rx_meta, rxs, rxs_d;
  logic [31:0] div_m1, div_cnt;
  logic [3:0]  os_cnt, bit_cnt, nbits;
  logic [8:0]  shreg;
  logic        frm_pend;
  logic        en, two_stop, fall, tick, sample, complete, frm_now;
  logic [15:0] rbr;
  logic        data_ready, framing_error, overrun;
  logic        parity_err_out;

  assign en       = bus.Receiver_Control[0];
  assign two_stop = (bus.Receiver_Control[8:7] == 2'b10);
  assign nbits    = (bus.Receiver_Control[4:1] >= 4'd5 && bus.Receiver_Control[4:1] <= 4'd9)
                    ? bus.Receiver_Control[4:1] : 4'd8;
  assign div_m1   = (bus.Baud_Rate_Holding_Register == 32'd0) ? 32'd0
                    : bus.Baud_Rate_Holding_Register - 32'd1;

  assign fall   = rxs_d & ~rxs;
  assign tick   = (state != S_IDLE) && (div_cnt == div_m1);
  assign sample = tick && (os_cnt == 4'd7);

`ifdef UART_RX_PARITY_EN
  logic par_en, par_odd, par_acc, par_pend, parity_error;
  logic unused_ctrl;
  assign par_en      = bus.Receiver_Control[5];
  assign par_odd     = bus.Receiver_Control[6];
  assign unused_ctrl = ^bus.Receiver_Control[15:9];
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{bus.Receiver_Control[15:9], bus.Receiver_Control[6:5]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      state   <= S_IDLE;
    end else begin
      rx_meta <= bus.RX;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    frm_now   = frm_pend;
    case (state)
      S_IDLE:  if (en && fall) state_nxt = S_START;
      S_START: if (sample) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (sample && bit_cnt == nbits - 4'd1) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = par_en ? S_PARITY : S_STOP1;
`else
          state_nxt = S_STOP1;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (sample) state_nxt = S_STOP1;
`endif
      S_STOP1: begin
        if (sample) begin
          if (!rxs) frm_now = 1'b1;
          if (two_stop) begin
            state_nxt = S_STOP2;
          end else begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (sample) begin
          if (!rxs) frm_now = 1'b1;
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Disabling mid-frame drops the frame without touching buffer or flags.
    if (!en && state != S_IDLE) begin
      state_nxt = S_IDLE;
      complete  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      div_cnt <= 32'd0;
      os_cnt  <= 4'd0;
    end else if (tick) begin
      div_cnt <= 32'd0;
      os_cnt  <= os_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      bit_cnt  <= 4'd0;
      shreg    <= 9'd0;
      frm_pend <= 1'b0;
    end else if (sample) begin
      if (state == S_DATA) begin
        shreg[bit_cnt] <= rxs;
        bit_cnt        <= bit_cnt + 4'd1;
      end
      if ((state == S_STOP1 || state == S_STOP2) && !rxs) frm_pend <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      par_acc  <= 1'b0;
      par_pend <= 1'b0;
    end else if (sample) begin
      if (state == S_DATA) par_acc <= par_acc ^ rxs;
      if (state == S_PARITY && ((par_acc ^ rxs) != par_odd)) par_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_error <= 1'b0;
    end else if (complete && (!data_ready || bus.read_ack)) begin
      parity_error <= par_pend;
    end else if (bus.read_ack) begin
      parity_error <= 1'b0;
    end
  end
  assign parity_err_out = parity_error;
`else
  assign parity_err_out = 1'b0;
`endif

  // Completion beats a same-cycle read_ack: the new word lands and overrun clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbr           <= 16'h0000;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (complete) begin
      if (!data_ready || bus.read_ack) begin
        rbr           <= {7'd0, shreg};
        data_ready    <= 1'b1;
        framing_error <= frm_now;
        overrun       <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (bus.read_ack) begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end
  end

  assign bus.Receiver_Buffer_Register = rbr;
  assign bus.Receiver_Status = {3'b000, (state != S_IDLE), overrun, framing_error,
                                parity_err_out, data_ready};

endmodule
